hazard_stall_ctrl: RTL and testbench

Parametrised pipeline hazard and stall controller for the in-order CPU, sitting beside the ID stage.
- Detects load-use hazards against any number of ID-stage source operands and stalls for a configurable load-result latency.
- Freezes the whole pipeline while the data memory is not ready, and flushes IF/ID on a taken branch resolved in EX.
- Keeps a saturating count of stall cycles for performance inspection.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/src_match.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/stall controller.
// Register addresses up to MAX_REG_W bits and up to MAX_SRC source operands are supported.
package hazard_pkg;

    localparam int unsigned MAX_SRC   = 4;
    localparam int unsigned MAX_REG_W = 8;

    typedef logic [MAX_SRC*MAX_REG_W-1:0] src_bus_t;
    typedef logic [MAX_REG_W-1:0]         reg_addr_t;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    localparam reg_addr_t REG_ZERO = '0;

    // Operand idx of a bus whose fields are w bits wide, zero-extended to MAX_REG_W.
    function automatic reg_addr_t get_src(input src_bus_t bus, input int unsigned idx,
                                          input int unsigned w);
        reg_addr_t mask;
        mask = '1;
        mask = mask >> (MAX_REG_W - w);
        return reg_addr_t'(bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/src_match.sv
// Load-use comparator: flags when any valid ID source operand reads the EX-stage load target.
module src_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2
) (
    input  logic                          i_mem_read,
    input  logic [REG_ADDR_W-1:0]         i_rt,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_regs,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    output logic                          o_hit
);

    src_bus_t  w_bus;
    reg_addr_t w_rt;
    logic      w_any;

    always_comb begin
        w_bus = '0;
        w_bus[NUM_SRC*REG_ADDR_W-1:0] = i_src_regs;
        w_rt = '0;
        w_rt[REG_ADDR_W-1:0] = i_rt;
    end

    always_comb begin
        w_any = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (i_src_valid[i] && (get_src(w_bus, i, REG_ADDR_W) == w_rt))
                w_any = 1'b1;
        end
    end

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign o_hit = i_mem_read && (w_rt != REG_ZERO) && w_any;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, memory-wait freeze,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         id_ex_rt,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_regs,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic                          branch_taken,
    input  logic                          mem_req,
    input  logic                          mem_ready,
    output logic                          pc_write,
    output logic                          if_id_write,
    output logic                          id_ex_bubble,
    output logic                          if_id_flush,
    output logic                          pipe_freeze,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam int unsigned CNT_BITS = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_next_cnt;
    logic [CNT_W-1:0]    r_stall;
    logic                w_hit;
    logic                w_mem_busy;

    src_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_SRC    (NUM_SRC)
    ) u_src_match (
        .i_mem_read  (id_ex_mem_read),
        .i_rt        (id_ex_rt),
        .i_src_regs  (id_src_regs),
        .i_src_valid (id_src_valid),
        .o_hit       (w_hit)
    );

    assign w_mem_busy = mem_req && !mem_ready;

    // Memory wait overrides everything and holds state; reset forces quiet outputs.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (w_mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_hit && (LOAD_LAT > 0)) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_next_state = LOAD_STALL;
                            w_next_cnt   = CNT_BITS'(LOAD_LAT - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_next_cnt   = r_cnt - CNT_BITS'(1);
                    if (r_cnt == CNT_BITS'(1))
                        w_next_state = RUN;
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (!pc_write && (r_stall != '1))
                r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with LOAD_LAT = 0, 1 and 3 instances on shared inputs.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [4:0]  rt;
    logic [9:0]  src;
    logic [1:0]  vld;
    logic        br;
    logic        mreq;
    logic        mrdy;

    logic        pc1, ifw1, bub1, fl1, fz1;
    logic        pc3, ifw3, bub3, fl3, fz3;
    logic        pc0, ifw0, bub0, fl0, fz0;
    logic [15:0] sc1, sc3, sc0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rt(rt),
        .id_src_regs(src), .id_src_valid(vld), .branch_taken(br),
        .mem_req(mreq), .mem_ready(mrdy), .pc_write(pc1), .if_id_write(ifw1),
        .id_ex_bubble(bub1), .if_id_flush(fl1), .pipe_freeze(fz1), .stall_cycles(sc1));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rt(rt),
        .id_src_regs(src), .id_src_valid(vld), .branch_taken(br),
        .mem_req(mreq), .mem_ready(mrdy), .pc_write(pc3), .if_id_write(ifw3),
        .id_ex_bubble(bub3), .if_id_flush(fl3), .pipe_freeze(fz3), .stall_cycles(sc3));

    hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(0), .CNT_W(16)) u_lat0 (
        .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rt(rt),
        .id_src_regs(src), .id_src_valid(vld), .branch_taken(br),
        .mem_req(mreq), .mem_ready(mrdy), .pc_write(pc0), .if_id_write(ifw0),
        .id_ex_bubble(bub0), .if_id_flush(fl0), .pipe_freeze(fz0), .stall_cycles(sc0));

    typedef struct {
        logic       mr;
        logic [4:0] rt;
        logic [9:0] src;
        logic [1:0] vld;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [4:0] exp1;
        logic       exp_pc0;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(logic m, logic [4:0] r, logic [4:0] s1, logic [4:0] s0,
                                 logic [1:0] v, logic b, logic q, logic y,
                                 logic [4:0] e1, logic e0);
        vec_t t;
        t.mr = m; t.rt = r; t.src = {s1, s0}; t.vld = v; t.br = b;
        t.mreq = q; t.mrdy = y; t.exp1 = e1; t.exp_pc0 = e0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [4:0] r, input logic [9:0] s,
                         input logic [1:0] v, input logic b, input logic q, input logic y);
        mem_read = m; rt = r; src = s; vld = v; br = b; mreq = q; mrdy = y;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hit5();
        drive(1'b1, 5'd5, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int exp_sc1;
        int exp_sc0;
        int exp_pc3[8];

        tbl[0]  = mkv(0, 5'd0,  5'd0,  5'd0, 2'b00, 0, 0, 0, 5'b11000, 1);
        tbl[1]  = mkv(1, 5'd5,  5'd0,  5'd5, 2'b01, 0, 0, 0, 5'b00100, 1);
        tbl[2]  = mkv(1, 5'd0,  5'd0,  5'd0, 2'b01, 0, 0, 0, 5'b11000, 1);
        tbl[3]  = mkv(1, 5'd5,  5'd5,  5'd3, 2'b01, 0, 0, 0, 5'b11000, 1);
        tbl[4]  = mkv(1, 5'd5,  5'd5,  5'd3, 2'b10, 0, 0, 0, 5'b00100, 1);
        tbl[5]  = mkv(1, 5'd5,  5'd0,  5'd5, 2'b01, 1, 0, 0, 5'b11110, 1);
        tbl[6]  = mkv(0, 5'd0,  5'd0,  5'd0, 2'b00, 1, 0, 0, 5'b11110, 1);
        tbl[7]  = mkv(0, 5'd0,  5'd0,  5'd0, 2'b00, 0, 1, 0, 5'b00001, 0);
        tbl[8]  = mkv(0, 5'd0,  5'd0,  5'd0, 2'b00, 0, 1, 1, 5'b11000, 1);
        tbl[9]  = mkv(1, 5'd5,  5'd0,  5'd5, 2'b01, 0, 1, 0, 5'b00001, 0);
        tbl[10] = mkv(0, 5'd0,  5'd0,  5'd0, 2'b00, 1, 1, 0, 5'b00001, 0);
        tbl[11] = mkv(0, 5'd5,  5'd5,  5'd5, 2'b11, 0, 0, 0, 5'b11000, 1);
        tbl[12] = mkv(1, 5'd31, 5'd31, 5'd0, 2'b11, 0, 0, 0, 5'b00100, 1);

        // Reset state: outputs quiet, counters clear.
        idle();
        rst = 1'b1;
        #3;
        chk("rst_outs_lat1", {27'd0, pc1, ifw1, bub1, fl1, fz1}, 32'b00100);
        chk("rst_outs_lat3", {27'd0, pc3, ifw3, bub3, fl3, fz3}, 32'b00100);
        chk("rst_sc1", {16'd0, sc1}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #2;
        chk("post_rst_pc1", {31'd0, pc1}, 32'd1);
        step();

        // Single-cycle decode table (LOAD_LAT=1 full outputs, LOAD_LAT=0 pc_write).
        exp_sc1 = 0;
        exp_sc0 = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].mr, tbl[i].rt, tbl[i].src, tbl[i].vld, tbl[i].br,
                  tbl[i].mreq, tbl[i].mrdy);
            #2;
            chk($sformatf("tbl%0d_lat1", i), {27'd0, pc1, ifw1, bub1, fl1, fz1},
                {27'd0, tbl[i].exp1});
            chk($sformatf("tbl%0d_lat0_pc", i), {31'd0, pc0}, {31'd0, tbl[i].exp_pc0});
            if (!tbl[i].exp1[4]) exp_sc1++;
            if (!tbl[i].exp_pc0) exp_sc0++;
            step();
        end
        idle();
        #2;
        chk("tbl_sc_lat1", {16'd0, sc1}, exp_sc1);
        chk("tbl_sc_lat0", {16'd0, sc0}, exp_sc0);

        // LOAD_LAT=3: exactly three stall cycles even with the hit held throughout.
        do_reset();
        exp_pc3 = '{0, 0, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 4; c++) begin
            if (c < 3) hit5(); else idle();
            #2;
            chk($sformatf("lat3_stall_c%0d_pc", c), {31'd0, pc3}, exp_pc3[c]);
            chk($sformatf("lat3_stall_c%0d_bub", c), {31'd0, bub3}, (c < 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("lat3_stall_sc", {16'd0, sc3}, 32'd3);

        // Hit together with a taken branch: flush wins, FSM stays in RUN.
        hit5();
        br = 1'b1;
        #2;
        chk("br_hit_lat3", {27'd0, pc3, ifw3, bub3, fl3, fz3}, 32'b11110);
        step();
        idle();
        #2;
        chk("br_hit_next_pc", {31'd0, pc3}, 32'd1);
        chk("br_hit_next_flush", {31'd0, fl3}, 32'd0);
        step();
        chk("br_hit_sc", {16'd0, sc3}, 32'd3);

        // LOAD_LAT=3 stall interrupted by four memory-wait cycles.
        do_reset();
        hit5();
        #2;
        chk("mw_c0_pc", {31'd0, pc3}, 32'd0);
        step();
        drive(1'b0, 5'd0, 10'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("mw_busy%0d", c), {27'd0, pc3, ifw3, bub3, fl3, fz3}, 32'b00001);
            step();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("mw_tail%0d_pc", c), {31'd0, pc3}, (c < 2) ? 32'd0 : 32'd1);
            chk($sformatf("mw_tail%0d_frz", c), {31'd0, fz3}, 32'd0);
            step();
        end
        chk("mw_sc", {16'd0, sc3}, 32'd7);

        // Reset asserted mid-stall aborts it at once.
        do_reset();
        hit5();
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {27'd0, pc3, ifw3, bub3, fl3, fz3}, 32'b00100);
        chk("rst_mid_sc", {16'd0, sc3}, 32'd0);
        step();
        rst = 1'b0;
        #2;
        chk("rst_mid_after_pc0", {31'd0, pc3}, 32'd1);
        step();
        #2;
        chk("rst_mid_after_pc1", {31'd0, pc3}, 32'd1);
        step();
        chk("rst_mid_after_sc", {16'd0, sc3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
